pipe_latch: RTL and testbench

Parametrised pipeline register for the five-stage processor, replacing the fixed FD/DX/XM/MW latch stubs with one block instantiated at every stage boundary. Each instance carries PC, instruction and NFIELDS generic data words, with a valid bit. It supports stall (hold), flush (bubble insertion) and saturating stall/bubble performance counters. The hazard unit drives stall/flush, and the datapath drives the fields.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_latch.sv | 94 +++++++++
 tb/tb_pipe_latch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the five-stage pipeline: word width, bubble instruction
// and the per-stage data field indices used with pipe_latch.
package pipe_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0000;

  // Data field slots per stage boundary (FD carries no data fields)
  localparam int DX_A = 0;
  localparam int DX_B = 1;
  localparam int XM_O = 0;
  localparam int XM_B = 1;
  localparam int MW_O = 0;
  localparam int MW_D = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones,
// cleared only by synchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_latch.sv
// Pipeline stage register carrying PC, instruction and NFIELDS data words with
// stall (hold), flush (bubble) and saturating stall/bubble counters; 1-cycle latency.
module pipe_latch #(
  parameter int                WIDTH    = pipe_pkg::WORD_W,
  parameter int                NFIELDS  = 2,
  parameter logic [WIDTH-1:0]  NOP_INSN = pipe_pkg::NOP_INSN,
  parameter int                CNT_W    = 16
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             stall,
  input  logic                                             flush,
  input  logic                                             in_valid,
  input  logic [WIDTH-1:0]                                 pc_in,
  input  logic [WIDTH-1:0]                                 insn_in,
  input  logic [((NFIELDS > 0) ? NFIELDS*WIDTH : 1)-1:0]   data_in,
  output logic                                             out_valid,
  output logic [WIDTH-1:0]                                 pc_out,
  output logic [WIDTH-1:0]                                 insn_out,
  output logic [((NFIELDS > 0) ? NFIELDS*WIDTH : 1)-1:0]   data_out,
  output logic [CNT_W-1:0]                                 stall_count,
  output logic [CNT_W-1:0]                                 bubble_count
);

  localparam int DW = NFIELDS * WIDTH;
  localparam int PW = 2 * WIDTH + DW;

  // Payload layout, MSB first: {pc, insn, data fields}
  logic [PW-1:0]    payload_q, payload_d;
  logic [PW-1:0]    load_vec, bubble_vec;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] insn_sel;
  logic             stall_inc, bubble_inc;

  assign insn_sel   = in_valid ? insn_in : NOP_INSN;
  assign bubble_vec = {{(PW-WIDTH){1'b0}}, NOP_INSN} << DW;

  generate
    if (NFIELDS > 0) begin : g_data
      assign load_vec = {pc_in, insn_sel, data_in};
      assign data_out = payload_q[DW-1:0];
    end else begin : g_nodata
      logic unused_data;
      assign unused_data = ^data_in;
      assign load_vec    = {pc_in, insn_sel};
      assign data_out    = '0;
    end
  endgenerate

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush) begin
      valid_d   = 1'b0;
      payload_d = bubble_vec;
    end else if (!stall) begin
      valid_d   = in_valid;
      payload_d = load_vec;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= bubble_vec;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = payload_q[PW-1 -: WIDTH];
  assign insn_out  = payload_q[DW +: WIDTH];

  // A load of an invalid slot writes a bubble just like a flush does
  assign stall_inc  = stall & ~flush;
  assign bubble_inc = flush | (~stall & ~in_valid);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (bubble_inc),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_pipe_latch.sv
// Bench for pipe_latch: default, 4-bit-counter and zero-field instances driven
// in lockstep and compared against a behavioural reference model.
module tb_pipe_latch;
  import pipe_pkg::*;

  logic        clock;
  logic        reset, stall, flush, in_valid;
  logic [31:0] pc_in, insn_in;
  logic [63:0] data_in;

  logic        m_vld, s_vld, n_vld;
  logic [31:0] m_pc, m_insn, s_pc, s_insn, n_pc, n_insn;
  logic [63:0] m_data, s_data;
  logic [0:0]  n_data;
  logic [15:0] m_stc, m_bbc, n_stc, n_bbc;
  logic [3:0]  s_stc, s_bbc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          r_vld;
  logic [31:0] r_pc, r_insn;
  logic [63:0] r_data;
  int          r_stalls, r_bubbles;

  pipe_latch u_main (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .insn_in(insn_in), .data_in(data_in),
    .out_valid(m_vld), .pc_out(m_pc), .insn_out(m_insn), .data_out(m_data),
    .stall_count(m_stc), .bubble_count(m_bbc)
  );

  pipe_latch #(.CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .insn_in(insn_in), .data_in(data_in),
    .out_valid(s_vld), .pc_out(s_pc), .insn_out(s_insn), .data_out(s_data),
    .stall_count(s_stc), .bubble_count(s_bbc)
  );

  pipe_latch #(.NFIELDS(0)) u_nof (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .insn_in(insn_in), .data_in(1'b0),
    .out_valid(n_vld), .pc_out(n_pc), .insn_out(n_insn), .data_out(n_data),
    .stall_count(n_stc), .bubble_count(n_bbc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat(int n, int max);
    return (n > max) ? 64'(max) : 64'(n);
  endfunction

  task automatic model_update();
    if (reset) begin
      r_vld = 0; r_pc = '0; r_insn = NOP_INSN; r_data = '0;
      r_stalls = 0; r_bubbles = 0;
    end else if (flush) begin
      r_vld = 0; r_pc = '0; r_insn = NOP_INSN; r_data = '0;
      r_bubbles++;
    end else if (stall) begin
      r_stalls++;
    end else begin
      r_vld  = in_valid;
      r_pc   = pc_in;
      r_insn = in_valid ? insn_in : NOP_INSN;
      r_data = data_in;
      if (!in_valid) r_bubbles++;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".m.vld"},  64'(m_vld),  64'(r_vld));
    chk({tag, ".m.pc"},   64'(m_pc),   64'(r_pc));
    chk({tag, ".m.insn"}, 64'(m_insn), 64'(r_insn));
    chk({tag, ".m.data"}, m_data,      r_data);
    chk({tag, ".m.stc"},  64'(m_stc),  sat(r_stalls, 65535));
    chk({tag, ".m.bbc"},  64'(m_bbc),  sat(r_bubbles, 65535));
    chk({tag, ".s.vld"},  64'(s_vld),  64'(r_vld));
    chk({tag, ".s.data"}, s_data,      r_data);
    chk({tag, ".s.stc"},  64'(s_stc),  sat(r_stalls, 15));
    chk({tag, ".s.bbc"},  64'(s_bbc),  sat(r_bubbles, 15));
    chk({tag, ".n.vld"},  64'(n_vld),  64'(r_vld));
    chk({tag, ".n.pc"},   64'(n_pc),   64'(r_pc));
    chk({tag, ".n.insn"}, 64'(n_insn), 64'(r_insn));
    chk({tag, ".n.stc"},  64'(n_stc),  sat(r_stalls, 65535));
    chk({tag, ".n.bbc"},  64'(n_bbc),  sat(r_bubbles, 65535));
  endtask

  task automatic drive(bit r, bit s, bit f, bit v, logic [31:0] pc, logic [31:0] insn,
                       logic [63:0] d);
    reset = r; stall = s; flush = f; in_valid = v;
    pc_in = pc; insn_in = insn; data_in = d;
  endtask

  task automatic step(string tag);
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    r_vld = 0; r_pc = '0; r_insn = NOP_INSN; r_data = '0; r_stalls = 0; r_bubbles = 0;

    // Reset and first load
    drive(1, 0, 0, 0, 32'h0, 32'h0, 64'h0);
    step("reset");
    chk("rst.insn", 64'(m_insn), 64'(NOP_INSN));
    chk("rst.stc", 64'(m_stc), 64'd0);
    drive(0, 0, 0, 1, 32'h10, 32'h2A00_0005, {32'h22, 32'h11});
    step("load1");
    chk("load1.pc", 64'(m_pc), 64'h10);
    chk("load1.insn", 64'(m_insn), 64'h2A00_0005);
    chk("load1.data", m_data, {32'h22, 32'h11});
    chk("load1.nof.pc", 64'(n_pc), 64'h10);
    chk("load1.bbc", 64'(m_bbc), 64'd0);

    // Three stall cycles with changed inputs, then release
    drive(0, 1, 0, 1, 32'h20, 32'h1111_2222, {32'h44, 32'h33});
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall3.pc", 64'(m_pc), 64'h10);
    chk("stall3.stc", 64'(m_stc), 64'd3);
    stall = 0;
    step("unstall");
    chk("unstall.pc", 64'(m_pc), 64'h20);

    // Flush beats stall
    drive(0, 1, 1, 1, 32'h40, 32'h5555_6666, {32'h66, 32'h55});
    step("flush");
    chk("flush.vld", 64'(m_vld), 64'd0);
    chk("flush.pc", 64'(m_pc), 64'd0);
    chk("flush.bbc", 64'(m_bbc), 64'd1);
    chk("flush.stc", 64'(m_stc), 64'd3);

    // Invalid load: pc/data load, insn forced to NOP
    drive(0, 0, 0, 0, 32'h30, 32'hDEAD_BEEF, {32'h88, 32'h77});
    step("inv");
    chk("inv.pc", 64'(m_pc), 64'h30);
    chk("inv.insn", 64'(m_insn), 64'(NOP_INSN));
    chk("inv.bbc", 64'(m_bbc), 64'd2);

    // Saturation of the 4-bit counter
    drive(1, 0, 0, 0, 32'h0, 32'h0, 64'h0);
    step("rst2");
    drive(0, 1, 0, 1, 32'h50, 32'h1234_5678, 64'h9);
    for (int i = 0; i < 21; i++) step("sat");
    chk("sat.s.stc", 64'(s_stc), 64'd15);
    chk("sat.m.stc", 64'(m_stc), 64'd21);

    // Reset while stalling with stall_count=5
    drive(1, 0, 0, 0, 32'h0, 32'h0, 64'h0);
    step("rst3");
    drive(0, 0, 0, 1, 32'h60, 32'hABCD_0001, 64'h1234);
    step("pre");
    stall = 1;
    for (int i = 0; i < 5; i++) step("stall5");
    chk("stall5.stc", 64'(m_stc), 64'd5);
    reset = 1;
    step("rst_mid");
    chk("rst_mid.vld", 64'(m_vld), 64'd0);
    chk("rst_mid.stc", 64'(m_stc), 64'd0);
    chk("rst_mid.pc", 64'(m_pc), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            $urandom, $urandom, {$urandom, $urandom});
      step("rand");
    end

    // First scenario again, watched on the zero-field instance
    drive(1, 0, 0, 0, 32'h0, 32'h0, 64'h0);
    step("rst4");
    drive(0, 0, 0, 1, 32'h10, 32'h2A00_0005, {32'h22, 32'h11});
    step("nof");
    chk("nof.vld", 64'(n_vld), 64'd1);
    chk("nof.pc", 64'(n_pc), 64'h10);
    chk("nof.insn", 64'(n_insn), 64'h2A00_0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
